// File: rtl/tv80_alu16_seq.sv
// rtl/tv80_alu16_seq.sv - 16-bit ADD/ADC/SBC sequencer issuing two chained 8-bit TV80 ALU steps
// Optional feature macro: TV80_ALU16_SUB_EN (op 11 = SUB16; otherwise op 11 passes a16/f_in through)
module tv80_alu16_seq #(
    parameter int Flag_C = 0,
    parameter int Flag_Z = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a16,
    input  logic [15:0] b16,
    input  logic [7:0]  f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  f_out,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic [1:0]  op_r;
    logic [7:0]  f_r;
    logic [7:0]  ft_r;
    logic [7:0]  chain_f;
    logic        pass_thru;

`ifdef TV80_ALU16_SUB_EN
    assign pass_thru = 1'b0;
`else
    assign pass_thru = (op_r == 2'b11);
`endif

    // High step consumes the low-byte carry (ADC/SBC chain) and zero (Z16 chain).
    always_comb begin
        chain_f         = ft_r;
        chain_f[Flag_C] = ft_r[Flag_C];
        chain_f[Flag_Z] = ft_r[Flag_Z];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            a_r    <= 16'h0000;
            b_r    <= 16'h0000;
            op_r   <= 2'b00;
            f_r    <= 8'h00;
            ft_r   <= 8'h00;
            result <= 16'h0000;
            f_out  <= 8'h00;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r  <= a16;
                        b_r  <= b16;
                        op_r <= op;
                        f_r  <= f_in;
                    end
                end
                S_LO: begin
                    result[7:0] <= pass_thru ? a_r[7:0] : alu_q;
                    ft_r        <= pass_thru ? f_r : alu_f;
                end
                S_HI: begin
                    result[15:8] <= pass_thru ? a_r[15:8] : alu_q;
                    f_out        <= pass_thru ? ft_r : alu_f;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx    = state;
        alu_op      = 4'b0000;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_f_in    = 8'h00;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_LO;
            end
            S_LO: begin
                state_nx = S_HI;
                if (!pass_thru) begin
                    alu_busa    = a_r[7:0];
                    alu_busb    = b_r[7:0];
                    alu_f_in    = f_r;
                    alu_arith16 = (op_r == 2'b00);
                    case (op_r)
                        2'b00:   alu_op = 4'b0000;
                        2'b01:   alu_op = 4'b0001;
                        2'b10:   alu_op = 4'b0011;
                        default: alu_op = 4'b0010;
                    endcase
                end
            end
            S_HI: begin
                state_nx = S_DONE;
                if (!pass_thru) begin
                    alu_busa    = a_r[15:8];
                    alu_busb    = b_r[15:8];
                    alu_f_in    = chain_f;
                    alu_arith16 = (op_r == 2'b00);
                    alu_z16     = (op_r != 2'b00);
                    alu_op      = op_r[1] ? 4'b0011 : 4'b0001;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// tb/tb_tv80_alu16_seq.sv - directed bench for tv80_alu16_seq with a behavioural TV80 8-bit ALU
module tb_tv80_alu16_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [7:0]  f_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  f_out;
    logic [3:0]  alu_op;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f;

    int n_vec = 0;
    int n_err = 0;

    tv80_alu16_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a16(a16), .b16(b16), .f_in(f_in),
        .busy(busy), .done(done), .result(result), .f_out(f_out),
        .alu_op(alu_op), .alu_busa(alu_busa), .alu_busb(alu_busb),
        .alu_arith16(alu_arith16), .alu_z16(alu_z16), .alu_f_in(alu_f_in),
        .alu_q(alu_q), .alu_f(alu_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // TV80 ALU add/sub group (ops 0000..0011); flags S7 Z6 Y5 H4 X3 P2 N1 C0
    logic       m_sub;
    logic       m_cin;
    logic [7:0] m_bx;
    logic [4:0] m_s4;
    logic [7:0] m_s7;
    logic [8:0] m_s8;
    always_comb begin
        m_sub = alu_op[1];
        m_bx  = m_sub ? ~alu_busb : alu_busb;
        m_cin = m_sub ^ (alu_op[0] & ~alu_op[2] & alu_f_in[0]);
        m_s4  = {1'b0, alu_busa[3:0]} + {1'b0, m_bx[3:0]} + {4'b0000, m_cin};
        m_s7  = {1'b0, alu_busa[6:0]} + {1'b0, m_bx[6:0]} + {7'b0000000, m_cin};
        m_s8  = {1'b0, alu_busa} + {1'b0, m_bx} + {8'h00, m_cin};
        alu_q = m_s8[7:0];
        alu_f = alu_f_in;
        alu_f[0] = m_s8[8] ^ m_sub;
        alu_f[1] = m_sub;
        alu_f[2] = m_s7[7] ^ m_s8[8];
        alu_f[3] = m_s8[3];
        alu_f[4] = m_s4[4] ^ m_sub;
        alu_f[5] = m_s8[5];
        alu_f[6] = (m_s8[7:0] == 8'h00) ? (alu_z16 ? alu_f_in[6] : 1'b1) : 1'b0;
        alu_f[7] = m_s8[7];
        if (alu_arith16) begin
            alu_f[7] = alu_f_in[7];
            alu_f[6] = alu_f_in[6];
            alu_f[2] = alu_f_in[2];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request at edge N and checks busy/done timing N+1..N+4 plus final values.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [7:0] f,
                          input logic [15:0] exp_r, input logic [7:0] exp_f);
        op = o; a16 = a; b16 = b; f_in = f; start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_lo_busy"}, {15'd0, busy}, 16'd1);
        chk({tag, "_lo_done"}, {15'd0, done}, 16'd0);
        tick();
        chk({tag, "_hi_done"}, {15'd0, done}, 16'd0);
        tick();
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_f_out"}, {8'h00, f_out}, {8'h00, exp_f});
        tick();
        chk({tag, "_idle_done"}, {15'd0, done}, 16'd0);
        chk({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_held"}, result, exp_r);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a16 = 16'h0000; b16 = 16'h0000; f_in = 8'h00;
        tick();
        tick();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_result", result, 16'h0000);
        chk("rst_f_out", {8'h00, f_out}, 16'h0000);
        chk("rst_alu_op", {12'd0, alu_op}, 16'h0000);
        reset = 1'b0;
        tick();

        // ADD16 with drive checks on both steps
        op = 2'b00; a16 = 16'h0FFF; b16 = 16'h0001; f_in = 8'hC4; start = 1'b1;
        tick();
        start = 1'b0;
        chk("add_lo_busa", {8'h00, alu_busa}, 16'h00FF);
        chk("add_lo_busb", {8'h00, alu_busb}, 16'h0001);
        chk("add_lo_op", {12'd0, alu_op}, 16'h0000);
        chk("add_lo_ar16", {15'd0, alu_arith16}, 16'd1);
        chk("add_lo_fin", {8'h00, alu_f_in}, 16'h00C4);
        chk("add_lo_done", {15'd0, done}, 16'd0);
        tick();
        chk("add_hi_busa", {8'h00, alu_busa}, 16'h000F);
        chk("add_hi_op", {12'd0, alu_op}, 16'h0001);
        chk("add_hi_z16", {15'd0, alu_z16}, 16'd0);
        chk("add_hi_fin", {8'h00, alu_f_in}, 16'h00D5);
        chk("add_hi_done", {15'd0, done}, 16'd0);
        tick();
        chk("add_done", {15'd0, done}, 16'd1);
        chk("add_result", result, 16'h1000);
        chk("add_f_out", {8'h00, f_out}, 16'h00D4);
        tick();
        chk("add_after_done", {15'd0, done}, 16'd0);
        chk("add_after_busy", {15'd0, busy}, 16'd0);

        run_op("adc_wrap", 2'b01, 16'hFFFF, 16'h0000, 8'h01, 16'h0000, 8'h51);
        run_op("sbc", 2'b10, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h3E);
        run_op("adc_hi0", 2'b01, 16'h0001, 16'h0000, 8'h00, 16'h0001, 8'h00);

        // start pulsed during LO must be dropped
        op = 2'b00; a16 = 16'h0FFF; b16 = 16'h0001; f_in = 8'hC4; start = 1'b1;
        tick();
        op = 2'b01; a16 = 16'hFFFF; b16 = 16'h0000; f_in = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_hi_busa", {8'h00, alu_busa}, 16'h000F);
        tick();
        chk("ign_done", {15'd0, done}, 16'd1);
        chk("ign_result", result, 16'h1000);
        chk("ign_f_out", {8'h00, f_out}, 16'h00D4);
        tick();
        chk("ign_no_queue", {15'd0, busy}, 16'd0);

        // reset during HI aborts without a done pulse
        op = 2'b10; a16 = 16'h8000; b16 = 16'h0001; f_in = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("abort_in_hi", {15'd0, busy}, 16'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_result", result, 16'h0000);
        tick();
        chk("abort_no_done", {15'd0, done}, 16'd0);

`ifdef TV80_ALU16_SUB_EN
        run_op("sub16", 2'b11, 16'h1234, 16'h1234, 8'h01, 16'h0000, 8'h42);
`else
        run_op("op11_pass", 2'b11, 16'h1234, 16'h1234, 8'h01, 16'h1234, 8'h01);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
